// File: rtl/game_io_adapter.sv
// Board-side adapter for an 8bitworkshop game core: pixel clock/enable divider,
// key synchronise + debounce, and frame-stepped paddle positions.
module game_io_adapter #(
    parameter int CLK_DIV   = 2,
    parameter int NKEYS     = 4,
    parameter int DB_CYCLES = 20000,
    parameter int PAD_W     = 8,
    parameter int PAD_STEP  = 2,
    parameter int PAD_INIT  = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] keys,
    input  logic             vsync_in,
    output logic             pix_ce,
    output logic             pix_clk,
    output logic [NKEYS-1:0] keys_db,
    output logic [NKEYS-1:0] key_press,
    output logic             frame_tick,
    output logic [PAD_W-1:0] hpaddle,
    output logic [PAD_W-1:0] vpaddle
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DBC_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
    localparam logic [DBC_W-1:0] DBC_MAX  = DBC_W'(DB_CYCLES - 1);
    localparam logic [PAD_W:0]   STEP_X   = (PAD_W + 1)'(PAD_STEP);
    localparam logic [PAD_W-1:0] PAD_RST  = PAD_W'(PAD_INIT);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        pix_ce_q, pix_ce_d;
    logic                        pix_clk_q, pix_clk_d;
    logic [NKEYS-1:0]            key_s1_q, key_s2_q;
    logic                        vs_s1_q, vs_s2_q, vs_prev_q;
    logic [NKEYS-1:0][DBC_W-1:0] dbc_q, dbc_d;
    logic [NKEYS-1:0]            keys_db_q, keys_db_d;
    logic [NKEYS-1:0]            db_prev_q;
    logic [NKEYS-1:0]            key_press_q, key_press_d;
    logic                        frame_tick_q, frame_tick_d;
    logic [PAD_W-1:0]            hpaddle_q, hpaddle_d;
    logic [PAD_W-1:0]            vpaddle_q, vpaddle_d;

    // Widen by one bit so underflow/overflow shows up in the top bit before clamping.
    function automatic logic [PAD_W-1:0] step_pad(input logic [PAD_W-1:0] pos,
                                                  input logic dec, input logic inc);
        logic [PAD_W:0] res;
        step_pad = pos;
        if (dec && !inc) begin
            res      = {1'b0, pos} - STEP_X;
            step_pad = res[PAD_W] ? '0 : res[PAD_W-1:0];
        end else if (inc && !dec) begin
            res      = {1'b0, pos} + STEP_X;
            step_pad = res[PAD_W] ? '1 : res[PAD_W-1:0];
        end
    endfunction

    always_comb begin
        cnt_d     = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        pix_ce_d  = (cnt_q == CNT_MAX);
        pix_clk_d = (CLK_DIV > 1) && (cnt_d >= CNT_HALF);
    end

    always_comb begin
        keys_db_d = keys_db_q;
        dbc_d     = dbc_q;
        for (int i = 0; i < NKEYS; i++) begin
            if (key_s2_q[i] != keys_db_q[i]) begin
                if (dbc_q[i] == DBC_MAX) begin
                    keys_db_d[i] = key_s2_q[i];
                    dbc_d[i]     = '0;
                end else begin
                    dbc_d[i] = dbc_q[i] + 1'b1;
                end
            end else begin
                dbc_d[i] = '0;
            end
        end
        key_press_d  = keys_db_q & ~db_prev_q;
        frame_tick_d = vs_s2_q & ~vs_prev_q;
    end

    // Paddles move only on the frame tick, using the debounced levels of that cycle.
    always_comb begin
        hpaddle_d = hpaddle_q;
        vpaddle_d = vpaddle_q;
        if (frame_tick_q) begin
            hpaddle_d = step_pad(hpaddle_q, keys_db_q[0], keys_db_q[1]);
            vpaddle_d = step_pad(vpaddle_q, keys_db_q[2], keys_db_q[3]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            pix_ce_q     <= 1'b0;
            pix_clk_q    <= 1'b0;
            key_s1_q     <= '0;
            key_s2_q     <= '0;
            vs_s1_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            vs_prev_q    <= 1'b0;
            dbc_q        <= '0;
            keys_db_q    <= '0;
            db_prev_q    <= '0;
            key_press_q  <= '0;
            frame_tick_q <= 1'b0;
            hpaddle_q    <= PAD_RST;
            vpaddle_q    <= PAD_RST;
        end else begin
            cnt_q        <= cnt_d;
            pix_ce_q     <= pix_ce_d;
            pix_clk_q    <= pix_clk_d;
            key_s1_q     <= keys;
            key_s2_q     <= key_s1_q;
            vs_s1_q      <= vsync_in;
            vs_s2_q      <= vs_s1_q;
            vs_prev_q    <= vs_s2_q;
            dbc_q        <= dbc_d;
            keys_db_q    <= keys_db_d;
            db_prev_q    <= keys_db_q;
            key_press_q  <= key_press_d;
            frame_tick_q <= frame_tick_d;
            hpaddle_q    <= hpaddle_d;
            vpaddle_q    <= vpaddle_d;
        end
    end

    assign pix_ce     = pix_ce_q;
    assign pix_clk    = pix_clk_q;
    assign keys_db    = keys_db_q;
    assign key_press  = key_press_q;
    assign frame_tick = frame_tick_q;
    assign hpaddle    = hpaddle_q;
    assign vpaddle    = vpaddle_q;

endmodule
